// File: rtl/axi_ddr_arbiter.sv
// axi_ddr_arbiter: N-master to single-DDR-port AXI-style arbiter.
// Address channel: round-robin grant through a two-state (IDLE/ISSUE) FSM.
// Write data: steered by a write-order FIFO of granted master indices.
// Read data: routed combinationally by the master index carried in the upper ID bits.
module axi_ddr_arbiter #(
  parameter int NUM_M    = 3,
  parameter int ID_W     = 6,
  parameter int DATA_W   = 64,
  parameter int WQ_DEPTH = 4,
  localparam int MI_W    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                         gclk,
  input  logic                         gresetn,
  // per-master address channels
  input  logic [NUM_M*ID_W-1:0]        m_aid,
  input  logic [NUM_M*32-1:0]          m_addr,
  input  logic [NUM_M-1:0]             m_avalid,
  input  logic [NUM_M-1:0]             m_awrite,
  input  logic [NUM_M*4-1:0]           m_alen,
  input  logic [NUM_M*2-1:0]           m_aburst,
  output logic [NUM_M-1:0]             m_aready,
  // per-master write data channels
  input  logic [NUM_M*DATA_W-1:0]      m_wdata,
  input  logic [NUM_M*(DATA_W/8)-1:0]  m_wstrb,
  input  logic [NUM_M-1:0]             m_wlast,
  input  logic [NUM_M-1:0]             m_wvalid,
  output logic [NUM_M-1:0]             m_wready,
  // per-master read channels
  output logic [NUM_M*ID_W-1:0]        m_rid,
  output logic [NUM_M*DATA_W-1:0]      m_rdata,
  output logic [NUM_M-1:0]             m_rlast,
  output logic [NUM_M-1:0]             m_rvalid,
  input  logic [NUM_M-1:0]             m_rready,
  // DDR address channel
  output logic [ID_W+MI_W-1:0]         aid_ddr,
  output logic [31:0]                  axi_addr_ddr,
  output logic                         avalid_ddr,
  output logic                         awrite_ddr,
  output logic [3:0]                   alen_ddr,
  output logic [1:0]                   aburst_ddr,
  input  logic                         aready_ddr,
  // DDR write channel
  output logic [DATA_W-1:0]            wdata_ddr,
  output logic [DATA_W/8-1:0]          wstrb_ddr,
  output logic                         wlast_ddr,
  output logic                         wvalid_ddr,
  input  logic                         wready_ddr,
  // DDR read channel
  input  logic [ID_W+MI_W-1:0]         rid_ddr,
  input  logic [DATA_W-1:0]            rdata_ddr,
  input  logic                         rlast_ddr,
  input  logic                         rvalid_ddr,
  output logic                         rready_ddr
);

  localparam int AW   = ID_W + MI_W;
  localparam int SW   = DATA_W / 8;
  localparam int QP_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CW   = QP_W + 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  // Master index reached by stepping 'off' places from 'base', wrapping at NUM_M.
  function automatic logic [MI_W-1:0] rr_idx(input logic [MI_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_M) s = s - NUM_M;
    return MI_W'(s);
  endfunction

  // address FSM state
  logic            state_q, state_d;
  logic [MI_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [MI_W-1:0] win_q, win_d;
  logic            avalid_q, avalid_d;
  logic            awrite_q, awrite_d;
  logic [AW-1:0]   aid_q, aid_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      alen_q, alen_d;
  logic [1:0]      aburst_q, aburst_d;

  // arbitration
  logic [NUM_M-1:0] elig;
  logic             arb_found;
  logic [MI_W-1:0]  arb_win;
  logic [ID_W-1:0]  sel_aid;
  logic [31:0]      sel_addr;
  logic             sel_awrite;
  logic [3:0]       sel_alen;
  logic [1:0]       sel_aburst;
  logic             aw_hs;

  // write-order FIFO
  logic [MI_W-1:0] wq_mem [WQ_DEPTH];
  logic [QP_W-1:0] wq_wr_q, wq_rd_q;
  logic [CW-1:0]   wq_cnt_q;
  logic            wq_full, wq_empty, wq_push, wq_pop;
  logic [MI_W-1:0] wq_head;

  logic [MI_W-1:0] rd_k;

  assign wq_full  = (wq_cnt_q == CW'(WQ_DEPTH));
  assign wq_empty = (wq_cnt_q == '0);
  assign wq_head  = wq_mem[wq_rd_q];
  assign aw_hs    = (state_q == ST_ISSUE) && aready_ddr;
  assign wq_push  = aw_hs && awrite_q;
  assign wq_pop   = wvalid_ddr && wready_ddr && wlast_ddr;

  assign aid_ddr      = aid_q;
  assign axi_addr_ddr = addr_q;
  assign avalid_ddr   = avalid_q;
  assign awrite_ddr   = awrite_q;
  assign alen_ddr     = alen_q;
  assign aburst_ddr   = aburst_q;

  // Round-robin search from rr_ptr; writes are held back while the order FIFO is full.
  always_comb begin
    elig       = m_avalid & ~(m_awrite & {NUM_M{wq_full}});
    arb_found  = 1'b0;
    arb_win    = '0;
    for (int j = 0; j < NUM_M; j++) begin
      if (!arb_found && elig[rr_idx(rr_ptr_q, j)]) begin
        arb_found = 1'b1;
        arb_win   = rr_idx(rr_ptr_q, j);
      end
    end
    sel_aid    = '0;
    sel_addr   = '0;
    sel_awrite = 1'b0;
    sel_alen   = '0;
    sel_aburst = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (arb_win == MI_W'(i)) begin
        sel_aid    = m_aid[i*ID_W +: ID_W];
        sel_addr   = m_addr[i*32 +: 32];
        sel_awrite = m_awrite[i];
        sel_alen   = m_alen[i*4 +: 4];
        sel_aburst = m_aburst[i*2 +: 2];
      end
    end
  end

  // Next-state for the address FSM: latch the winner in IDLE, hold it in ISSUE until accepted.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    avalid_d = avalid_q;
    awrite_d = awrite_q;
    aid_d    = aid_q;
    addr_d   = addr_q;
    alen_d   = alen_q;
    aburst_d = aburst_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d  = ST_ISSUE;
          avalid_d = 1'b1;
          win_d    = arb_win;
          aid_d    = {arb_win, sel_aid};
          addr_d   = sel_addr;
          awrite_d = sel_awrite;
          alen_d   = sel_alen;
          aburst_d = sel_aburst;
        end
      end
      ST_ISSUE: begin
        if (aready_ddr) begin
          state_d  = ST_IDLE;
          avalid_d = 1'b0;
          rr_ptr_d = (win_q == MI_W'(NUM_M - 1)) ? '0 : win_q + MI_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address FSM registers; reset drops any in-flight request so arbitration restarts from master 0.
  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      avalid_q <= 1'b0;
      awrite_q <= 1'b0;
      aid_q    <= '0;
      addr_q   <= '0;
      alen_q   <= '0;
      aburst_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      avalid_q <= avalid_d;
      awrite_q <= awrite_d;
      aid_q    <= aid_d;
      addr_q   <= addr_d;
      alen_q   <= alen_d;
      aburst_q <= aburst_d;
    end
  end

  // Address-accept pulse goes back to the granted master on the DDR handshake cycle.
  always_comb begin
    m_aready = '0;
    for (int i = 0; i < NUM_M; i++) begin
      m_aready[i] = aw_hs && (win_q == MI_W'(i));
    end
  end

  // Write-order FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn) begin
      wq_wr_q  <= '0;
      wq_rd_q  <= '0;
      wq_cnt_q <= '0;
    end else begin
      if (wq_push) wq_wr_q <= wq_wr_q + QP_W'(1);
      if (wq_pop)  wq_rd_q <= wq_rd_q + QP_W'(1);
      case ({wq_push, wq_pop})
        2'b10:   wq_cnt_q <= wq_cnt_q + CW'(1);
        2'b01:   wq_cnt_q <= wq_cnt_q - CW'(1);
        default: wq_cnt_q <= wq_cnt_q;
      endcase
    end
  end

  // FIFO storage holds only master indices; entries are meaningful only between the pointers.
  always_ff @(posedge gclk) begin
    if (wq_push) wq_mem[wq_wr_q] <= win_q;
  end

  // W steering: only the master at the FIFO head sees wready, so others' data waits its turn.
  always_comb begin
    wvalid_ddr = 1'b0;
    wdata_ddr  = '0;
    wstrb_ddr  = '0;
    wlast_ddr  = 1'b0;
    m_wready   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!wq_empty && (wq_head == MI_W'(i))) begin
        wvalid_ddr  = m_wvalid[i];
        wdata_ddr   = m_wdata[i*DATA_W +: DATA_W];
        wstrb_ddr   = m_wstrb[i*SW +: SW];
        wlast_ddr   = m_wlast[i];
        m_wready[i] = wready_ddr;
      end
    end
  end

  assign rd_k    = rid_ddr[AW-1 -: MI_W];
  assign m_rid   = {NUM_M{rid_ddr[ID_W-1:0]}};
  assign m_rdata = {NUM_M{rdata_ddr}};
  assign m_rlast = {NUM_M{rlast_ddr}};

  // R steering by ID index; beats carrying an unknown index are accepted and dropped.
  always_comb begin
    m_rvalid   = '0;
    rready_ddr = 1'b1;
    for (int i = 0; i < NUM_M; i++) begin
      if (rd_k == MI_W'(i)) begin
        m_rvalid[i] = rvalid_ddr;
        rready_ddr  = m_rready[i];
      end
    end
    if (!gresetn) begin
      m_rvalid   = '0;
      rready_ddr = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_ddr_arbiter.sv
// Directed testbench for axi_ddr_arbiter (NUM_M=3, ID_W=6, DATA_W=64, WQ_DEPTH=4).
module tb_axi_ddr_arbiter;
  localparam int NUM_M = 3;
  localparam int ID_W  = 6;
  localparam int DW    = 64;
  localparam int SW    = DW / 8;
  localparam int MI_W  = 2;

  logic                   gclk = 1'b0;
  logic                   gresetn;
  logic [NUM_M*ID_W-1:0]  m_aid;
  logic [NUM_M*32-1:0]    m_addr;
  logic [NUM_M-1:0]       m_avalid, m_awrite, m_aready;
  logic [NUM_M*4-1:0]     m_alen;
  logic [NUM_M*2-1:0]     m_aburst;
  logic [NUM_M*DW-1:0]    m_wdata;
  logic [NUM_M*SW-1:0]    m_wstrb;
  logic [NUM_M-1:0]       m_wlast, m_wvalid, m_wready;
  logic [NUM_M*ID_W-1:0]  m_rid;
  logic [NUM_M*DW-1:0]    m_rdata;
  logic [NUM_M-1:0]       m_rlast, m_rvalid, m_rready;
  logic [ID_W+MI_W-1:0]   aid_ddr, rid_ddr;
  logic [31:0]            axi_addr_ddr;
  logic                   avalid_ddr, awrite_ddr, aready_ddr;
  logic [3:0]             alen_ddr;
  logic [1:0]             aburst_ddr;
  logic [DW-1:0]          wdata_ddr, rdata_ddr;
  logic [SW-1:0]          wstrb_ddr;
  logic                   wlast_ddr, wvalid_ddr, wready_ddr;
  logic                   rlast_ddr, rvalid_ddr, rready_ddr;

  int vectors     = 0;
  int miscompares = 0;

  axi_ddr_arbiter #(.NUM_M(NUM_M), .ID_W(ID_W), .DATA_W(DW), .WQ_DEPTH(4)) dut (
    .gclk(gclk), .gresetn(gresetn),
    .m_aid(m_aid), .m_addr(m_addr), .m_avalid(m_avalid), .m_awrite(m_awrite),
    .m_alen(m_alen), .m_aburst(m_aburst), .m_aready(m_aready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .aid_ddr(aid_ddr), .axi_addr_ddr(axi_addr_ddr), .avalid_ddr(avalid_ddr),
    .awrite_ddr(awrite_ddr), .alen_ddr(alen_ddr), .aburst_ddr(aburst_ddr),
    .aready_ddr(aready_ddr),
    .wdata_ddr(wdata_ddr), .wstrb_ddr(wstrb_ddr), .wlast_ddr(wlast_ddr),
    .wvalid_ddr(wvalid_ddr), .wready_ddr(wready_ddr),
    .rid_ddr(rid_ddr), .rdata_ddr(rdata_ddr), .rlast_ddr(rlast_ddr),
    .rvalid_ddr(rvalid_ddr), .rready_ddr(rready_ddr)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_a(input int i, input logic v, input logic w, input logic [5:0] id,
                       input logic [31:0] addr, input logic [3:0] len);
    m_avalid[i]            = v;
    m_awrite[i]            = w;
    m_aid[i*ID_W +: ID_W]  = id;
    m_addr[i*32 +: 32]     = addr;
    m_alen[i*4 +: 4]       = len;
  endtask

  task automatic set_w(input int i, input logic v, input logic last, input logic [63:0] d,
                       input logic [7:0] strb);
    m_wvalid[i]          = v;
    m_wlast[i]           = last;
    m_wdata[i*DW +: DW]  = d;
    m_wstrb[i*SW +: SW]  = strb;
  endtask

  initial begin
    int grants1;
    gresetn = 1'b0;
    m_aid = '0; m_addr = '0; m_avalid = '0; m_awrite = '0; m_alen = '0;
    m_aburst = {NUM_M{2'b01}};
    m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_rready = '0;
    aready_ddr = 1'b0; wready_ddr = 1'b0;
    rid_ddr = '0; rdata_ddr = '0; rlast_ddr = 1'b0; rvalid_ddr = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_avalid", avalid_ddr, 0);
    chk("rst_aid", aid_ddr, 0);
    chk("rst_addr", axi_addr_ddr, 0);
    chk("rst_wvalid", wvalid_ddr, 0);
    chk("rst_aready", m_aready, 0);
    chk("rst_wready", m_wready, 0);
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_rready", rready_ddr, 0);
    gresetn = 1'b1;

    // three concurrent reads: round-robin order 0,1,2 at cycles 1,3,5
    set_a(0, 1, 0, 6'h01, 32'h0000_1000, 4'd0);
    set_a(1, 1, 0, 6'h02, 32'h0000_2000, 4'd0);
    set_a(2, 1, 0, 6'h03, 32'h0000_3000, 4'd0);
    aready_ddr = 1'b1;
    tick();
    chk("rr_c1_avalid", avalid_ddr, 1);
    chk("rr_c1_aid", aid_ddr, 8'h01);
    chk("rr_c1_addr", axi_addr_ddr, 32'h0000_1000);
    chk("rr_c1_aburst", aburst_ddr, 2'b01);
    chk("rr_c1_mready", m_aready, 3'b001);
    tick();
    m_avalid[0] = 1'b0;
    chk("rr_c2_avalid", avalid_ddr, 0);
    tick();
    chk("rr_c3_aid", aid_ddr, 8'h42);
    chk("rr_c3_mready", m_aready, 3'b010);
    tick();
    m_avalid[1] = 1'b0;
    chk("rr_c4_avalid", avalid_ddr, 0);
    tick();
    chk("rr_c5_aid", aid_ddr, 8'h83);
    chk("rr_c5_addr", axi_addr_ddr, 32'h0000_3000);
    chk("rr_c5_mready", m_aready, 3'b100);
    tick();
    m_avalid[2] = 1'b0;
    chk("rr_c6_avalid", avalid_ddr, 0);

    // write ordering: master 1 (4 beats) then master 0 (2 beats)
    wready_ddr = 1'b1;
    set_a(1, 1, 1, 6'h0A, 32'h0000_4000, 4'd3);
    set_w(1, 1, 0, 64'hA1A1_0000_0000_0000, 8'hFF);
    set_w(0, 1, 0, 64'hB0B0_0000_0000_0000, 8'h0F);
    settle();
    chk("w_empty_wvalid", wvalid_ddr, 0);
    chk("w_empty_mwready", m_wready, 0);
    tick();
    chk("w_m1_aid", aid_ddr, 8'h4A);
    chk("w_m1_awrite", awrite_ddr, 1);
    chk("w_m1_alen", alen_ddr, 4'd3);
    chk("w_m1_pre_wvalid", wvalid_ddr, 0);
    tick();
    m_avalid[1] = 1'b0;
    set_a(0, 1, 1, 6'h05, 32'h0000_5000, 4'd1);
    settle();
    chk("w_b1_wvalid", wvalid_ddr, 1);
    chk("w_b1_data", wdata_ddr, 64'hA1A1_0000_0000_0000);
    chk("w_b1_strb", wstrb_ddr, 8'hFF);
    chk("w_b1_mwready", m_wready, 3'b010);
    chk("w_b1_last", wlast_ddr, 0);
    tick();
    set_w(1, 1, 0, 64'hA1A1_0000_0000_0001, 8'hFF);
    settle();
    chk("w_b2_data", wdata_ddr, 64'hA1A1_0000_0000_0001);
    chk("w_m0_aid", aid_ddr, 8'h05);
    tick();
    m_avalid[0] = 1'b0;
    set_w(1, 1, 0, 64'hA1A1_0000_0000_0002, 8'hFF);
    settle();
    chk("w_b3_data", wdata_ddr, 64'hA1A1_0000_0000_0002);
    chk("w_b3_mwready", m_wready, 3'b010);
    tick();
    set_w(1, 1, 1, 64'hA1A1_0000_0000_0003, 8'hFF);
    settle();
    chk("w_b4_data", wdata_ddr, 64'hA1A1_0000_0000_0003);
    chk("w_b4_last", wlast_ddr, 1);
    tick();
    set_w(1, 0, 0, 64'h0, 8'h00);
    settle();
    chk("w_b5_data", wdata_ddr, 64'hB0B0_0000_0000_0000);
    chk("w_b5_strb", wstrb_ddr, 8'h0F);
    chk("w_b5_mwready", m_wready, 3'b001);
    chk("w_b5_last", wlast_ddr, 0);
    tick();
    set_w(0, 1, 1, 64'hB0B0_0000_0000_0001, 8'h0F);
    settle();
    chk("w_b6_data", wdata_ddr, 64'hB0B0_0000_0000_0001);
    chk("w_b6_last", wlast_ddr, 1);
    tick();
    set_w(0, 0, 0, 64'h0, 8'h00);
    settle();
    chk("w_done_wvalid", wvalid_ddr, 0);
    chk("w_done_mwready", m_wready, 0);

    // fill the write-order FIFO with 4 master-1 writes while DDR stalls W
    wready_ddr = 1'b0;
    set_a(1, 1, 1, 6'h0B, 32'h0000_6000, 4'd0);
    grants1 = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (m_aready[1]) grants1++;
    end
    chk("wq_fill_grants", grants1, 4);
    m_avalid[1] = 1'b0;
    m_awrite[1] = 1'b0;
    set_a(2, 1, 1, 6'h22, 32'h0000_7000, 4'd0);
    set_a(0, 1, 0, 6'h30, 32'h0000_8000, 4'd0);
    tick();
    chk("wq_full_read_avalid", avalid_ddr, 1);
    chk("wq_full_read_aid", aid_ddr, 8'h30);
    chk("wq_full_read_awrite", awrite_ddr, 0);
    tick();
    m_avalid[0] = 1'b0;
    tick();
    chk("wq_full_block1", avalid_ddr, 0);
    tick();
    chk("wq_full_block2", avalid_ddr, 0);
    set_w(1, 1, 1, 64'h0000_0000_0000_00C1, 8'hFF);
    wready_ddr = 1'b1;
    settle();
    chk("wq_pop_wvalid", wvalid_ddr, 1);
    chk("wq_pop_wlast", wlast_ddr, 1);
    tick();
    set_w(1, 0, 0, 64'h0, 8'h00);
    wready_ddr = 1'b0;
    tick();
    chk("wq_m2_avalid", avalid_ddr, 1);
    chk("wq_m2_aid", aid_ddr, 8'hA2);
    chk("wq_m2_awrite", awrite_ddr, 1);
    tick();
    m_avalid[2] = 1'b0;
    m_awrite[2] = 1'b0;

    // move rr_ptr to 1, then reset while a request is held and a burst is in progress
    set_a(0, 1, 0, 6'h31, 32'h0000_9000, 4'd0);
    tick();
    tick();
    m_avalid[0] = 1'b0;
    aready_ddr = 1'b0;
    set_a(1, 1, 0, 6'h12, 32'h0000_A000, 4'd0);
    set_w(1, 1, 0, 64'h0000_0000_0000_00D1, 8'hFF);
    wready_ddr = 1'b1;
    tick();
    chk("rst_pre_aid", aid_ddr, 8'h52);
    chk("rst_pre_wvalid", wvalid_ddr, 1);
    tick();
    chk("rst_pre_hold", avalid_ddr, 1);
    #2;
    gresetn = 1'b0;
    #1;
    chk("rst_mid_avalid", avalid_ddr, 0);
    chk("rst_mid_wvalid", wvalid_ddr, 0);
    chk("rst_mid_mwready", m_wready, 0);
    chk("rst_mid_aid", aid_ddr, 0);
    set_a(0, 1, 0, 6'h01, 32'h0000_1000, 4'd0);
    set_a(1, 1, 0, 6'h12, 32'h0000_A000, 4'd0);
    set_a(2, 1, 0, 6'h03, 32'h0000_3000, 4'd0);
    set_w(1, 0, 0, 64'h0, 8'h00);
    wready_ddr = 1'b0;
    aready_ddr = 1'b1;
    tick();
    chk("rst_hold_avalid", avalid_ddr, 0);
    gresetn = 1'b1;
    tick();
    chk("rst_after_avalid", avalid_ddr, 1);
    chk("rst_after_aid", aid_ddr, 8'h01);
    tick();
    m_avalid = '0;

    // read routing
    rid_ddr   = 8'h95;
    rvalid_ddr = 1'b1;
    rdata_ddr = 64'hDEAD_BEEF_0123_4567;
    rlast_ddr = 1'b1;
    m_rready  = 3'b000;
    settle();
    chk("r_k2_rvalid", m_rvalid, 3'b100);
    chk("r_k2_rid", m_rid[2*ID_W +: ID_W], 6'h15);
    chk("r_k2_rready_lo", rready_ddr, 0);
    chk("r_k2_rdata", m_rdata[2*DW +: DW], 64'hDEAD_BEEF_0123_4567);
    chk("r_k2_rlast", m_rlast, 3'b111);
    m_rready = 3'b100;
    settle();
    chk("r_k2_rready_hi", rready_ddr, 1);
    rid_ddr  = 8'hC7;
    m_rready = 3'b000;
    settle();
    chk("r_bad_rready", rready_ddr, 1);
    chk("r_bad_rvalid", m_rvalid, 3'b000);
    rid_ddr  = 8'h47;
    m_rready = 3'b010;
    settle();
    chk("r_k1_rvalid", m_rvalid, 3'b010);
    chk("r_k1_rready", rready_ddr, 1);
    m_rready = 3'b101;
    settle();
    chk("r_k1_rready_lo", rready_ddr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
